// File: rtl/mdu_pkg.sv
`default_nettype none
// ------------------------------------------------------------
// mdu_pkg : operation codes and latency helper for the MDU
// Rev 1.0
// ------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  // Cycles from the start cycle to the done cycle of a long operation.
  function automatic int MDU_LATENCY(input int width);
    return width + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ------------------------------------------------------------
// mdu_if : request/result bundle between execute stage and MDU
// Rev 1.0
// ------------------------------------------------------------
interface mdu_if #(
  parameter int WIDTH = 32
);
  import mdu_pkg::*;

  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, flush,
    output busy, done, div_by_zero, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ------------------------------------------------------------
// mdu : iterative shift-add multiply / restoring divide, HI/LO
// Rev 1.0
// ------------------------------------------------------------
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic nRST,
  mdu_if.slave bus
);

  localparam int c_CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [2*WIDTH:0]  r_acc;
  logic [WIDTH-1:0]  r_opnd;     // multiplicand or divisor magnitude
  logic              r_is_div;
  logic              r_neg_a;    // product / quotient sign
  logic              r_neg_b;    // remainder sign
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic              r_done;
  logic              r_dbz;

  logic              w_signed;
  logic              w_is_div;
  logic              w_is_mul;
  logic              w_dz;
  logic [WIDTH-1:0]  w_abs_rs;
  logic [WIDTH-1:0]  w_abs_rt;

  always_comb begin
    w_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    w_is_div = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
    w_is_mul = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
    w_dz     = w_is_div && (bus.rt == '0);
    w_abs_rs = (w_signed && bus.rs[WIDTH-1]) ? -bus.rs : bus.rs;
    w_abs_rt = (w_signed && bus.rt[WIDTH-1]) ? -bus.rt : bus.rt;
  end

  logic [WIDTH:0]    w_madd;
  logic [2*WIDTH:0]  w_sh;
  logic [WIDTH+1:0]  w_diff;
  logic [2*WIDTH:0]  w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]  w_quo;
  logic [WIDTH-1:0]  w_rem;

  // Multiply keeps the partial product in the upper half and shifts right;
  // divide shifts left and subtracts the divisor from the upper half.
  always_comb begin
    w_madd = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_sh   = {r_acc[2*WIDTH-1:0], 1'b0};
    w_diff = {1'b0, w_sh[2*WIDTH:WIDTH]} - {2'b00, r_opnd};
    if (r_is_div) begin
      w_step = w_diff[WIDTH+1] ? w_sh : {w_diff[WIDTH:0], w_sh[WIDTH-1:1], 1'b1};
    end else begin
      w_step = {1'b0, w_madd, r_acc[WIDTH-1:1]};
    end
    w_prod = r_neg_a ? -r_acc[2*WIDTH-1:0]     : r_acc[2*WIDTH-1:0];
    w_quo  = r_neg_a ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
    w_rem  = r_neg_b ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            if (w_is_mul || (w_is_div && !w_dz)) begin
              r_state  <= RUN;
              r_cnt    <= '0;
              r_acc    <= {{(WIDTH+1){1'b0}}, (w_is_div ? w_abs_rs : w_abs_rt)};
              r_opnd   <= w_is_div ? w_abs_rt : w_abs_rs;
              r_is_div <= w_is_div;
              r_neg_a  <= w_signed && (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
              r_neg_b  <= w_signed && bus.rs[WIDTH-1];
            end else if (w_dz) begin
              r_hi   <= bus.rs;
              r_lo   <= '1;
              r_done <= 1'b1;
              r_dbz  <= 1'b1;
            end else if (bus.op == MDU_MTHI) begin
              r_hi   <= bus.rs;
              r_done <= 1'b1;
            end else if (bus.op == MDU_MTLO) begin
              r_lo   <= bus.rs;
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.flush) begin
            r_state <= IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + c_CW'(1);
            if (r_cnt == c_CW'(WIDTH - 1)) begin
              r_state <= SIGN;
            end
          end
        end
        SIGN: begin
          r_state <= IDLE;
          if (!bus.flush) begin
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ------------------------------------------------------------
// tb_mdu : directed vectors for the multiply/divide unit
// Rev 1.0
// ------------------------------------------------------------
module tb_mdu;
  import mdu_pkg::*;

  logic clk;
  logic nRST;
  int   n_checks;
  int   n_errors;

  mdu_if #(.WIDTH(32)) bus ();

  mdu #(.WIDTH(32)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcyc);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = a;
    bus.rt    = b;
    @(posedge clk);
    lat  = 0;
    bcyc = 0;
    while (1) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (bus.busy) bcyc++;
      if (bus.done) break;
      if (lat >= 200) begin
        check("done_timeout", 64'(lat), 64'd0);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bcyc, ndone;
    n_checks   = 0;
    n_errors   = 0;
    nRST       = 1'b0;
    bus.start  = 1'b0;
    bus.op     = MDU_MULT;
    bus.rs     = '0;
    bus.rt     = '0;
    bus.flush  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi",   64'(bus.hi), 64'h0);
    check("rst_lo",   64'(bus.lo), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_dbz",  64'(bus.div_by_zero), 64'h0);
    nRST = 1'b1;
    @(negedge clk);

    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
    check("multu_hi",   64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_lo",   64'(bus.lo), 64'h0000_0001);
    check("multu_lat",  64'(lat),    64'(MDU_LATENCY(32)));
    check("multu_busy", 64'(bcyc),   64'd33);
    check("multu_dbz",  64'(bus.div_by_zero), 64'h0);

    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5, lat, bcyc);
    check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);

    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcyc);
    check("div_lo",  64'(bus.lo), 64'hFFFF_FFFD);
    check("div_hi",  64'(bus.hi), 64'hFFFF_FFFF);
    check("div_lat", 64'(lat),    64'd34);

    run_op(MDU_DIVU, 32'd7, 32'd2, lat, bcyc);
    check("divu_lo", 64'(bus.lo), 64'h3);
    check("divu_hi", 64'(bus.hi), 64'h1);

    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
    check("divmn_lo",  64'(bus.lo), 64'h8000_0000);
    check("divmn_hi",  64'(bus.hi), 64'h0);
    check("divmn_dbz", 64'(bus.div_by_zero), 64'h0);

    run_op(MDU_DIVU, 32'h1234, 32'h0, lat, bcyc);
    check("dz_lat",  64'(lat), 64'd1);
    check("dz_busy", 64'(bcyc), 64'd0);
    check("dz_dbz",  64'(bus.div_by_zero), 64'h1);
    check("dz_hi",   64'(bus.hi), 64'h1234);
    check("dz_lo",   64'(bus.lo), 64'hFFFF_FFFF);
    @(negedge clk);
    check("dz_pulse", 64'({bus.done, bus.div_by_zero}), 64'h0);

    run_op(MDU_MTLO, 32'h0, 32'h0, lat, bcyc);
    check("mtlo_lo", 64'(bus.lo), 64'h0);
    run_op(MDU_MTHI, 32'hA5A5_A5A5, 32'h0, lat, bcyc);
    check("mthi_hi",   64'(bus.hi), 64'hA5A5_A5A5);
    check("mthi_lat",  64'(lat),    64'd1);
    check("mthi_busy", 64'(bcyc),   64'd0);

    // MULTU 2x3 with a retried start at cycle 5, squashed at cycle 10.
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.rs = 32'd2; bus.rt = 32'd3;
    @(posedge clk);
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      if (bus.done) ndone++;
      if (k == 9)  check("fl_busy_before", 64'(bus.busy), 64'h1);
      if (k == 11) check("fl_busy_after",  64'(bus.busy), 64'h0);
      if (k == 5)  bus.start = 1'b1;
      if (k == 10) bus.flush = 1'b1;
    end
    check("fl_no_done", 64'(ndone), 64'd0);
    check("fl_hi", 64'(bus.hi), 64'hA5A5_A5A5);
    check("fl_lo", 64'(bus.lo), 64'h0);
    check("fl_idle", 64'(bus.busy), 64'h0);

    // MULTU 2x3 to completion; a start with other operands at cycle 5 is ignored.
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.rs = 32'd2; bus.rt = 32'd3;
    @(posedge clk);
    ndone = 0;
    lat   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        lat = k;
      end
      if (k == 5) begin
        bus.start = 1'b1; bus.rs = 32'd7; bus.rt = 32'd7;
      end
    end
    check("ign_ndone", 64'(ndone), 64'd1);
    check("ign_lat",   64'(lat),   64'd34);
    check("ign_hi",    64'(bus.hi), 64'h0);
    check("ign_lo",    64'(bus.lo), 64'h6);

    // DIV in flight, asynchronous reset at cycle 12.
    bus.start = 1'b1; bus.op = MDU_DIV; bus.rs = 32'd100; bus.rt = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    nRST = 1'b0;
    #1;
    check("ar_hi",   64'(bus.hi),   64'h0);
    check("ar_lo",   64'(bus.lo),   64'h0);
    check("ar_busy", 64'(bus.busy), 64'h0);
    check("ar_done", 64'(bus.done), 64'h0);
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    run_op(MDU_DIV, 32'd100, 32'hFFFF_FFF9, lat, bcyc);
    check("ar_div_lo",  64'(bus.lo), 64'hFFFF_FFF2);
    check("ar_div_hi",  64'(bus.hi), 64'h2);
    check("ar_div_lat", 64'(lat),    64'd34);

    // start+flush together while idle, then an undefined op code.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MDU_MTHI; bus.rs = 32'hDEAD;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.op    = mdu_op_t'(3'd6);
    bus.rs    = 32'hBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.done || bus.busy) ndone++;
      @(negedge clk);
    end
    check("sf_quiet", 64'(ndone),  64'd0);
    check("sf_hi",    64'(bus.hi), 64'h2);
    check("sf_lo",    64'(bus.lo), 64'hFFFF_FFF2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu.md
# mdu

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the multi-cycle companion to the single-cycle ALU in the execute stage. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO through a start/busy/done handshake. HI and LO are held internally and are always readable by MFHI/MFLO forwarding logic.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; even, at least 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while idle.
- op  in  3  mdu_op_t operation, valid with start.
- rs  in  WIDTH  dividend or multiplicand; value for MTHI/MTLO.
- rt  in  WIDTH  divisor or multiplier.
- flush  in  1  abort the in-flight operation (pipeline squash).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  single-cycle pulse; HI/LO hold the new result in the same cycle.
- div_by_zero  out  1  qualifies done; high only for a DIV/DIVU with rt==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE.
- States:
  - IDLE to RUN: start with MULT/MULTU/DIV/DIVU, except a divide with rt==0.
  - RUN to SIGN: after WIDTH iterations.
  - SIGN to IDLE.
- Operand capture for signed ops: store absolute values and record the result signs.
  - Product sign = rs[W-1] ^ rt[W-1].
  - Quotient sign = rs[W-1] ^ rt[W-1].
  - Remainder sign = rs[W-1].
- Unsigned ops: signs are forced to 0.
- Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - SIGN negates the 2*WIDTH product if the product sign is set.
  - Result: hi = product[2W-1:W], lo = product[W-1:0].
- Divide: restoring, one quotient bit per iteration.
  - SIGN negates quotient and remainder independently.
  - Result: lo = quotient (truncated toward zero), hi = remainder (sign of dividend).
  - DIV most-negative / -1: lo=most-negative, hi=0, no flag.
- Divide by zero:
  - No RUN. On the accept edge: hi=rs, lo=all ones.
  - Next cycle: done=1 and div_by_zero=1.
- MTHI/MTLO: write hi (or lo) = rs on the accept edge, done=1 next cycle, busy stays 0.
- Undefined op codes: ignored (no write, no done).
- start while busy: ignored, no queueing.
- flush:
  - When RUN or SIGN: the next edge returns to IDLE. No hi/lo write, no done.
  - Same cycle as a start while IDLE: flush wins, start dropped.
  - Same cycle as the SIGN edge: flush wins.
- nRST asserted mid-operation: immediately forces all reset values; the in-flight result is lost.

## Timing
- Accept edge E0, when start=1 and state=IDLE.
- Long ops (multiply, nonzero-divisor divide):
  - Iterations on edges E1..E_WIDTH.
  - SIGN writes hi/lo on edge E_(WIDTH+1); done is high in the following cycle.
  - Latency is WIDTH+2 cycles from start to done. For WIDTH=32, done appears 34 cycles after start.
  - busy is high from after E0 through the cycle before done.
- Short ops (MTHI/MTLO, divide by zero): done is high in the cycle after E0.
- done and div_by_zero are registered and low in every other cycle.
- A new start is accepted in the done cycle (state is IDLE). Back-to-back long ops therefore have a throughput of WIDTH+2.
- hi/lo never change except on a result-write edge, a short-op edge, or reset.

## Structure
- Add to cpu_types_pkg:
  - mdu_op_t, 3-bit enum: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5.
  - MDU_LATENCY = WIDTH+2, as a function for benches.
- The state enum (IDLE, RUN, SIGN) is local to mdu.
- Iteration counter width: $clog2(WIDTH)+1.
- No sub-module: multiply and divide share one 2*WIDTH+1-bit accumulator and shifter, with the mode selected by a captured op bit.

## Test plan
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF:
  - Result: hi=0xFFFFFFFE, lo=0x00000001.
  - done exactly 34 cycles after start; busy high for 33 cycles.
- MULT rs=-3 (0xFFFFFFFD), rt=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed and unsigned divides:
  - DIV rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU rs=7, rt=2 → lo=3, hi=1.
  - DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=0x1234, rt=0 → done and div_by_zero high in the next cycle; hi=0x1234, lo=0xFFFFFFFF.
- MTHI 0xA5A5A5A5, then MULTU 2×3:
  - Pulse start for MULTU 2×3 again at cycle 5 of the first MULTU: ignored.
  - Assert flush at cycle 10 of the first MULTU → busy=0 next cycle, no done, hi=0xA5A5A5A5, lo=0 unchanged.
- Reset and start/flush collisions:
  - DIV in flight, nRST pulsed low at cycle 12 → hi=lo=0, busy=done=0 immediately.
  - A following start after reset release completes normally.
  - start+flush together while IDLE → nothing happens.
